// File: rtl/rx_fifo_read_ctrl.sv
// Rx FIFO read-side controller: pops words, holds the current word for the AHB
// register file, counts delivered words and flags reads that find no data.
module rx_fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  rx_enable,
  input  logic                  rx_rd_req,
  input  logic                  irq_en,
  input  logic                  clr_status,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_irq,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  rx_word_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pop_ok;
  logic                  rd_en;
  logic                  underrun_event;

  // A pop issued while reset is held would be lost, so reset also blocks it.
  assign pop_ok = HRESETn & rx_enable & ~fifo_empty;

  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      ST_IDLE: rd_en = pop_ok;
      ST_FULL: rd_en = pop_ok & rx_rd_req;
      default: rd_en = 1'b0;
    endcase
  end

  assign underrun_event = rx_rd_req & (state_q != ST_FULL);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_FULL;
        data_d  = fifo_rd_data;
        valid_d = 1'b1;
      end
      ST_FULL: begin
        if (rx_rd_req) begin
          cnt_d   = cnt_q + CNT_ONE;
          valid_d = 1'b0;
          state_d = rd_en ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (clr_status) cnt_d = '0;
    underrun_d = underrun_event | (underrun_q & ~clr_status);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fifo_rd_en  = rd_en;
  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_irq      = valid_q & irq_en;
  assign underrun    = underrun_q;
  assign rx_word_cnt = cnt_q;

endmodule
